// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: sequencer states, ALU opcodes and opcode classification helpers.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_ARG_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE,
        S_TRAP
    } state_e;

    localparam logic [OPC_ARG_W-1:0] OP_ADD = 16'd3;
    localparam logic [OPC_ARG_W-1:0] OP_SUB = 16'd4;
    localparam logic [OPC_ARG_W-1:0] OP_AND = 16'd5;
    localparam logic [OPC_ARG_W-1:0] OP_OR  = 16'd6;
    localparam logic [OPC_ARG_W-1:0] OP_SHR = 16'd7;
    localparam logic [OPC_ARG_W-1:0] OP_SHL = 16'd8;
    localparam logic [OPC_ARG_W-1:0] OP_ROR = 16'd9;
    localparam logic [OPC_ARG_W-1:0] OP_ROL = 16'd10;
    localparam logic [OPC_ARG_W-1:0] OP_MUL = 16'd15;
    localparam logic [OPC_ARG_W-1:0] OP_DIV = 16'd16;

    // Single-bit datapath strobes, grouped so the FSM can clear them in one default.
    typedef struct packed {
        logic PCout;
        logic MARin;
        logic IncPC;
        logic PCin;
        logic Read;
        logic MDRin;
        logic MDRout;
        logic IRin;
        logic Yin;
        logic Zin;
        logic Zlowout;
        logic Zhighout;
        logic LOin;
        logic HIin;
    } strobes_t;

    function automatic logic is_legal(input logic [OPC_ARG_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Wide ops return a 64-bit result written back through LO then HI.
    function automatic logic is_wide(input logic [OPC_ARG_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Handshake and strobe bundle between the control sequencer (master) and the datapath (slave).
interface alu_seq_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned OP_W   = 5
);
    logic              start;
    logic              mem_ready;
    logic [DATA_W-1:0] IR;

    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;

    logic [NREGS-1:0]  Rout;
    logic [NREGS-1:0]  Rin;
    logic [OP_W-1:0]   alu_op;
    logic              done;
    logic              illegal;

    modport master (
        input  start, mem_ready, IR,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, LOin, HIin,
               Rout, Rin, alu_op, done, illegal
    );

    modport slave (
        output start, mem_ready, IR,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, LOin, HIin,
               Rout, Rin, alu_op, done, illegal
    );
endinterface

// File: rtl/reg_decode.sv
// Binary register index to one-hot select, all zeros when disabled.
module reg_decode #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned REG_AW = $clog2(NREGS)
) (
    input  logic              en_i,
    input  logic [REG_AW-1:0] sel_i,
    output logic [NREGS-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions on the single-bus datapath.
module alu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned OP_W   = 5
) (
    input  logic           Clock,
    input  logic           Resetn,
    alu_seq_ctrl_if.master bus
);

    localparam int unsigned REG_AW = $clog2(NREGS);
    localparam int unsigned LOW_W  = DATA_W - OP_W - 3 * REG_AW;

    state_e            state_q, state_d;
    strobes_t          strb;
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] ra, rb, rc;
    logic [REG_AW-1:0] rout_sel;
    logic              rout_en, rin_en;
    logic              legal, wide;
    logic [OP_W-1:0]   alu_op_c;
    logic              done_c, illegal_c;
    logic              ir_low_unused;

    assign opcode = bus.IR[DATA_W-1 -: OP_W];
    assign ra     = bus.IR[DATA_W-OP_W-1 -: REG_AW];
    assign rb     = bus.IR[DATA_W-OP_W-REG_AW-1 -: REG_AW];
    assign rc     = bus.IR[DATA_W-OP_W-2*REG_AW-1 -: REG_AW];
    assign ir_low_unused = ^bus.IR[LOW_W-1:0];

    assign legal = is_legal(OPC_ARG_W'(opcode));
    assign wide  = is_wide(OPC_ARG_W'(opcode));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore strobes; IR only steers decode from T3 on.
    always_comb begin
        state_d   = state_q;
        strb      = '0;
        rout_en   = 1'b0;
        rout_sel  = rb;
        rin_en    = 1'b0;
        alu_op_c  = '0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_T0;
            end
            S_T0: begin
                strb.PCout = 1'b1;
                strb.MARin = 1'b1;
                strb.IncPC = 1'b1;
                strb.Zin   = 1'b1;
                state_d    = S_T1;
            end
            S_T1: begin
                strb.Zlowout = 1'b1;
                strb.PCin    = 1'b1;
                strb.Read    = 1'b1;
                strb.MDRin   = 1'b1;
                state_d      = bus.mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                strb.Read  = 1'b1;
                strb.MDRin = 1'b1;
                if (bus.mem_ready) state_d = S_T2;
            end
            S_T2: begin
                strb.MDRout = 1'b1;
                strb.IRin   = 1'b1;
                state_d     = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    rout_en  = 1'b1;
                    strb.Yin = 1'b1;
                    state_d  = S_T4;
                end else begin
                    state_d  = S_TRAP;
                end
            end
            S_T4: begin
                rout_en  = 1'b1;
                rout_sel = rc;
                strb.Zin = 1'b1;
                alu_op_c = opcode;
                state_d  = S_T5;
            end
            S_T5: begin
                strb.Zlowout = 1'b1;
                if (wide) begin
                    strb.LOin = 1'b1;
                    state_d   = S_T6;
                end else begin
                    rin_en    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_T6: begin
                strb.Zhighout = 1'b1;
                strb.HIin     = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = bus.start ? S_T0 : S_IDLE;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    reg_decode #(.NREGS(NREGS), .REG_AW(REG_AW)) u_rout_dec (
        .en_i     (rout_en),
        .sel_i    (rout_sel),
        .onehot_o (bus.Rout)
    );

    reg_decode #(.NREGS(NREGS), .REG_AW(REG_AW)) u_rin_dec (
        .en_i     (rin_en),
        .sel_i    (ra),
        .onehot_o (bus.Rin)
    );

    assign bus.PCout    = strb.PCout;
    assign bus.MARin    = strb.MARin;
    assign bus.IncPC    = strb.IncPC;
    assign bus.PCin     = strb.PCin;
    assign bus.Read     = strb.Read;
    assign bus.MDRin    = strb.MDRin;
    assign bus.MDRout   = strb.MDRout;
    assign bus.IRin     = strb.IRin;
    assign bus.Yin      = strb.Yin;
    assign bus.Zin      = strb.Zin;
    assign bus.Zlowout  = strb.Zlowout;
    assign bus.Zhighout = strb.Zhighout;
    assign bus.LOin     = strb.LOin;
    assign bus.HIin     = strb.HIin;
    assign bus.alu_op   = alu_op_c;
    assign bus.done     = done_c;
    assign bus.illegal  = illegal_c;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: checks every strobe, one-hot select and pulse cycle by cycle.
module tb_alu_seq_ctrl;

    // Strobe vector order: PCout MARin IncPC PCin Read MDRin MDRout IRin Yin Zin Zlowout Zhighout LOin HIin
    localparam logic [13:0] E_NONE = 14'b00000000000000;
    localparam logic [13:0] E_T0   = 14'b11100000010000;
    localparam logic [13:0] E_T1   = 14'b00011100001000;
    localparam logic [13:0] E_T1W  = 14'b00001100000000;
    localparam logic [13:0] E_T2   = 14'b00000011000000;
    localparam logic [13:0] E_T3   = 14'b00000000100000;
    localparam logic [13:0] E_T4   = 14'b00000000010000;
    localparam logic [13:0] E_T5N  = 14'b00000000001000;
    localparam logic [13:0] E_T5W  = 14'b00000000001010;
    localparam logic [13:0] E_T6   = 14'b00000000000101;

    // ADD Ra=3 Rb=3 Rc=7; MUL Ra=1 Rb=2 Rc=4; opcode 11111 with zero register fields
    localparam logic [31:0] IR_ADD = 32'h199B8000;
    localparam logic [31:0] IR_MUL = 32'h78920000;
    localparam logic [31:0] IR_BAD = 32'hF8000000;

    logic Clock;
    logic Resetn;
    int   checks;
    int   failures;
    int   pcin_cnt;
    int   pc0;

    alu_seq_ctrl_if #(.DATA_W(32), .NREGS(16), .OP_W(5)) bus ();

    alu_seq_ctrl #(.DATA_W(32), .NREGS(16), .OP_W(5)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (Resetn && bus.PCin) pcin_cnt <= pcin_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk_out(input string tag, input logic [13:0] es, input logic [15:0] erout,
                           input logic [15:0] erin, input logic [4:0] eop,
                           input logic edone, input logic eill);
        logic [52:0] obs;
        logic [52:0] exp;
        obs = {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin, bus.MDRout,
               bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin,
               bus.Rout, bus.Rin, bus.alu_op, bus.done, bus.illegal};
        exp = {es, erout, erin, eop, edone, eill};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    // Check the current cycle, then advance to the next one.
    task automatic cyc(input string tag, input logic [13:0] es, input logic [15:0] erout,
                       input logic [15:0] erin, input logic [4:0] eop,
                       input logic edone, input logic eill);
        chk_out(tag, es, erout, erin, eop, edone, eill);
        step();
    endtask

    task automatic launch();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        int d0;
        int d1;
        logic prev_done;
        checks        = 0;
        failures      = 0;
        pcin_cnt      = 0;
        Resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.IR        = '0;
        repeat (2) step();
        chk_out("reset", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Narrow ADD, zero wait states
        Resetn = 1'b1;
        bus.IR = IR_ADD;
        step();
        cyc("idle", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        launch();
        pc0 = pcin_cnt;
        cyc("add_t0", E_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("add_t1", E_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("add_t2", E_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("add_t3", E_T3, 16'h0008, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("add_t4", E_T4, 16'h0080, 16'h0, 5'd3, 1'b0, 1'b0);
        cyc("add_t5", E_T5N, 16'h0, 16'h0008, 5'd0, 1'b0, 1'b0);
        cyc("add_done", E_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        cyc("add_idle", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        chk_int("add_pcin", pcin_cnt - pc0, 1);

        // Three wait states in fetch
        bus.mem_ready = 1'b0;
        launch();
        pc0 = pcin_cnt;
        cyc("ws_t0", E_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ws_t1", E_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ws_w1", E_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ws_w2", E_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("ws_w3", E_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ws_t2", E_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ws_t3", E_T3, 16'h0008, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ws_t4", E_T4, 16'h0080, 16'h0, 5'd3, 1'b0, 1'b0);
        cyc("ws_t5", E_T5N, 16'h0, 16'h0008, 5'd0, 1'b0, 1'b0);
        cyc("ws_done", E_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        chk_int("ws_pcin", pcin_cnt - pc0, 1);

        // Wide MUL: LO then HI, no general register write
        bus.IR = IR_MUL;
        launch();
        cyc("mul_t0", E_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("mul_t1", E_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("mul_t2", E_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("mul_t3", E_T3, 16'h0004, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("mul_t4", E_T4, 16'h0010, 16'h0, 5'd15, 1'b0, 1'b0);
        cyc("mul_t5", E_T5W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("mul_t6", E_T6, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("mul_done", E_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        cyc("mul_idle", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Illegal opcode traps after T3 and ignores start until reset
        bus.IR = IR_BAD;
        launch();
        cyc("ill_t0", E_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ill_t1", E_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ill_t2", E_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("ill_t3", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        bus.start = 1'b1;
        cyc("ill_trap0", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        cyc("ill_trap1", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        bus.start = 1'b0;
        Resetn    = 1'b0;
        cyc("ill_trap2", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        Resetn    = 1'b1;
        cyc("ill_reset", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        chk_out("ill_idle", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Reset asserted during T4 aborts before write-back
        bus.IR = IR_ADD;
        launch();
        cyc("rm_t0", E_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("rm_t1", E_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("rm_t2", E_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("rm_t3", E_T3, 16'h0008, 16'h0, 5'd0, 1'b0, 1'b0);
        Resetn = 1'b0;
        cyc("rm_t4", E_T4, 16'h0080, 16'h0, 5'd3, 1'b0, 1'b0);
        Resetn = 1'b1;
        cyc("rm_after", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        cyc("rm_idle", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Back-to-back with start held high
        d0 = -1;
        d1 = -1;
        prev_done = 1'b0;
        bus.start = 1'b1;
        step();
        for (int i = 0; i < 40 && d1 < 0; i++) begin
            if (prev_done) chk_out("b2b_t0", E_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
            if (bus.done) begin
                if (d0 < 0) d0 = i;
                else        d1 = i;
            end
            prev_done = bus.done;
            if (d1 < 0) step();
        end
        bus.start = 1'b0;
        chk_int("b2b_first_done", d0, 6);
        chk_int("b2b_gap", d1 - d0, 7);
        step();
        chk_out("b2b_idle", E_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
